theta_tracker: RTL and testbench
================================

# theta_tracker

Rotational-position tracker for the spinning display: turns the raw IR index sensor into a discretized angle that the column/voxel fetch logic consumes. It is the next generation of the angle tracker: input synchronisation and debounce, an explicit lock/stall state machine, a programmable angular offset, and a per-step strobe. It sits between the IR sensor pin and the frame-buffer address generator, all in the 100 MHz domain.

## Interface
Parameters:
- COUNT_WIDTH, 27, width of the cycle counters; covers at least 0.2 s per revolution at 100 MHz.
- ROTATIONAL_RES, 1024, angular steps per revolution; must be a power of two ≥ 2.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles before the filtered IR level changes; ≥ 1.
- STALL_CYCLES, 50_000_000, revolution length at which the rotor is declared stopped; < 2^COUNT_WIDTH.
- AVG_LOG2, 3, IIR smoothing shift; used only with the averaging feature.

Ports. One clock; reset is synchronous and active-high.
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- ir_tripped  in  1  raw, asynchronous IR sensor level.
- theta_offset  in  log2(RES)  angle added to the internal angle, modulo RES; sampled every cycle.
- dtheta  out  log2(RES)  current discretized angle.
- dtheta_valid  out  1  high only in LOCKED.
- theta_step  out  1  one-cycle pulse when the internal angle advances or is reset by an index.
- index_pulse  out  1  one-cycle pulse on each accepted IR rising edge.
- period  out  COUNT_WIDTH  revolution length in cycles (raw or smoothed).
- stalled  out  1  high from a stall until the next index.

## Operation
- Input path: 2-flop synchronizer, then debounce. The filtered level takes the synchronized value after DEBOUNCE_CYCLES consecutive equal samples that differ from it. A rising edge of the filtered level produces an index.
- theta counter: cleared on index, otherwise +1, saturating at all-ones.
- States:
  - IDLE (reset state): on index go to MEASURE.
  - MEASURE: on index go to LOCKED and load period with theta.
  - LOCKED: on index stay in LOCKED and update period.
  - Any state with theta == STALL_CYCLES-1 and no index: go to IDLE and set stalled. stalled clears on the next index.
- cp = period >> log2(RES), clamped to a minimum of 1. It updates in the same cycle as period.
- Angle counter: counts to cp-1, then advances the internal angle. The internal angle saturates at RES-1 and never wraps; only an index returns it to 0. In IDLE/MEASURE the angle holds 0.
- dtheta = (internal angle + theta_offset) mod RES; the adder truncates to log2(RES) bits.

## Timing
- Reset values: dtheta=0, dtheta_valid=0, theta_step=0, index_pulse=0, period=0, stalled=0, state IDLE, filtered level 0.
- Latency: ir_tripped stable high from cycle 0 gives index_pulse in cycle DEBOUNCE_CYCLES+3.
- index_pulse in cycle N gives, in cycle N+1: internal angle 0, the updated period/cp/state, and theta_step=1. dtheta reflects this one cycle later, in N+2.
- An angle advance registered in cycle M gives theta_step=1 in M and the updated dtheta in M+1.
- Index and stall in the same cycle: index wins; stalled is not set.
- Index while the angle is saturated at RES-1: the angle goes to 0 normally.
- rst_in in mid-revolution: every register returns to its reset value on the next edge, including the debounce and synchronizer registers.

## Configuration
- THETA_PERIOD_AVG_EN defined: the MEASURE→LOCKED transition seeds period with the raw measurement. Each later index applies period ← period + ((theta − period) >>> AVG_LOG2), using signed COUNT_WIDTH+1 arithmetic.
- THETA_PERIOD_AVG_EN undefined: period = last raw measurement; AVG_LOG2 is ignored.

## Structure
- Package theta_pkg holds the state enum (IDLE, MEASURE, LOCKED) and a localparam function for log2(RES) width.
- Sub-module ir_debounce contains the synchronizer, the debounce counter and rising-edge detection. Its output is a level plus a rise pulse, parametrised by DEBOUNCE_CYCLES.

## Test plan
- DEBOUNCE_CYCLES=4, ir_tripped high for 3 cycles, then low → no index_pulse; held 4+ cycles → index_pulse at cycle 7.
- RES=16, indices every 1600 cycles → lock after the 2nd index, period=1599, dtheta advances every 99 cycles, dtheta_valid=1.
- Same stream with theta_offset=5 → dtheta=5 one cycle after theta_step following index, wraps 15→0 mid-revolution.
- Next index arrives late (2000 cycles) → dtheta holds 15 until index, then 0+offset.
- STALL_CYCLES=3000, indices stop → stalled=1, dtheta_valid=0 at theta=2999; next index clears stalled, state MEASURE.
- With THETA_PERIOD_AVG_EN, AVG_LOG2=3, periods 1599 then 2399 → period = 1599 + (800>>3) = 1699.

Source files
------------

// File: rtl/theta_pkg.sv
// theta_tracker shared types: tracker states and angle-width helper.
// Optional THETA_PERIOD_AVG_EN build smooths the revolution period.
package theta_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_e;

    function automatic int res_w(input int res);
        return (res > 1) ? $clog2(res) : 1;
    endfunction

endpackage

// File: rtl/theta_tracker_ir_debounce.sv
// IR index front end: 2-flop synchronizer, stable-count debounce
// and rising-edge pulse of the filtered level.
module ir_debounce
    import theta_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic ir_raw,
    output logic level,
    output logic rise
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // any sample equal to the filtered level restarts the count
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ir_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/theta_tracker.sv
// Rotor angle tracker: IR index -> lock/stall FSM -> offset angle.
// Define THETA_PERIOD_AVG_EN for IIR-smoothed revolution period.
module theta_tracker
    import theta_pkg::*;
#(
    parameter int COUNT_WIDTH     = 27,
    parameter int ROTATIONAL_RES  = 1024,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STALL_CYCLES    = 50_000_000,
    parameter int AVG_LOG2        = 3
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ir_tripped,
    input  logic [res_w(ROTATIONAL_RES)-1:0]  theta_offset,
    output logic [res_w(ROTATIONAL_RES)-1:0]  dtheta,
    output logic                              dtheta_valid,
    output logic                              theta_step,
    output logic                              index_pulse,
    output logic [COUNT_WIDTH-1:0]            period,
    output logic                              stalled
);

    localparam int RW = res_w(ROTATIONAL_RES);
    localparam int CW = COUNT_WIDTH;
    localparam logic [CW-1:0] STALL_AT = CW'(STALL_CYCLES - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] theta_q;
    logic [CW-1:0] theta_d;
    logic [CW-1:0] period_q;
    logic [CW-1:0] period_d;
    logic [CW-1:0] period_upd;
    logic [CW-1:0] cp_q;
    logic [CW-1:0] cp_d;
    logic [CW-1:0] acnt_q;
    logic [CW-1:0] acnt_d;
    logic [RW-1:0] angle_q;
    logic [RW-1:0] angle_d;
    logic [RW-1:0] dtheta_q;
    logic [RW-1:0] dtheta_d;
    logic          valid_q;
    logic          valid_d;
    logic          step_q;
    logic          step_d;
    logic          index_q;
    logic          stalled_q;
    logic          stalled_d;
    logic          ir_rise;
    logic          unused_ir_level;

    ir_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .ir_raw(ir_tripped),
        .level (unused_ir_level),
        .rise  (ir_rise)
    );

`ifdef THETA_PERIOD_AVG_EN
    logic signed [CW:0] avg_diff;
    logic signed [CW:0] avg_step;
    logic               unused_avg_msb;

    always_comb begin
        avg_diff = $signed({1'b0, theta_q}) - $signed({1'b0, period_q});
        avg_step = avg_diff >>> AVG_LOG2;
        period_upd = period_q + avg_step[CW-1:0];
    end

    assign unused_avg_msb = avg_step[CW];
`else
    logic unused_avg;

    assign unused_avg = (AVG_LOG2 < 0);
    assign period_upd = theta_q;
`endif

    always_comb begin
        state_d   = state_q;
        theta_d   = (&theta_q) ? theta_q : theta_q + CW'(1);
        period_d  = period_q;
        angle_d   = angle_q;
        acnt_d    = acnt_q;
        step_d    = 1'b0;
        stalled_d = stalled_q;
        if (index_q) begin
            theta_d   = '0;
            angle_d   = '0;
            acnt_d    = '0;
            step_d    = 1'b1;
            stalled_d = 1'b0;
            unique case (1'b1)
                (state_q == IDLE): state_d = MEASURE;
                (state_q == MEASURE): begin
                    state_d  = LOCKED;
                    period_d = theta_q;
                end
                (state_q == LOCKED): period_d = period_upd;
                default: state_d = IDLE;
            endcase
        end else if (theta_q == STALL_AT) begin
            state_d   = IDLE;
            stalled_d = 1'b1;
            angle_d   = '0;
            acnt_d    = '0;
        end else if (state_q == LOCKED) begin
            // angle saturates; only an index brings it back to 0
            if (acnt_q == cp_q - CW'(1)) begin
                acnt_d = '0;
                if (angle_q != '1) begin
                    angle_d = angle_q + RW'(1);
                    step_d  = 1'b1;
                end
            end else begin
                acnt_d = acnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        cp_d = period_d >> RW;
        if (cp_d == '0) begin
            cp_d = CW'(1);
        end
    end

    assign dtheta_d = angle_q + theta_offset;
    assign valid_d  = (state_d == LOCKED);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            theta_q   <= '0;
            period_q  <= '0;
            cp_q      <= CW'(1);
            acnt_q    <= '0;
            angle_q   <= '0;
            dtheta_q  <= '0;
            valid_q   <= 1'b0;
            step_q    <= 1'b0;
            index_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            theta_q   <= theta_d;
            period_q  <= period_d;
            cp_q      <= cp_d;
            acnt_q    <= acnt_d;
            angle_q   <= angle_d;
            dtheta_q  <= dtheta_d;
            valid_q   <= valid_d;
            step_q    <= step_d;
            index_q   <= ir_rise;
            stalled_q <= stalled_d;
        end
    end

    assign dtheta       = dtheta_q;
    assign dtheta_valid = valid_q;
    assign theta_step   = step_q;
    assign index_pulse  = index_q;
    assign period       = period_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_theta_tracker.sv
// Scoreboard bench for theta_tracker: directed index stream,
// expected events queued by stimulus, checked by a monitor.
module tb_theta_tracker;

    localparam int CW    = 27;
    localparam int RES   = 16;
    localparam int DEB   = 4;
    localparam int STALL = 3000;
    localparam int AVG   = 3;

    typedef struct {
        int cyc;
        bit idx;
        bit stp;
        bit stl;
        bit vld;
        int per;
        bit chk_now;
        int dt_now;
        bit chk_nxt;
        int dt_nxt;
    } ev_t;

    typedef struct {
        int gap;
        int off;
        bit lock;
        int per_raw;
        int per_avg;
        bit stl;
    } row_t;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          ir_tripped = 1'b0;
    logic [3:0]    theta_offset = 4'd0;
    logic [3:0]    dtheta;
    logic          dtheta_valid;
    logic          theta_step;
    logic          index_pulse;
    logic [CW-1:0] period;
    logic          stalled;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    ev_t q[$];
    bit  pend = 1'b0;
    int  pend_dt = 0;
    bit  stl_prev = 1'b0;

    // hand-computed: period after each index, raw and IIR-smoothed
    row_t rows[7] = '{
        '{gap:    0, off: 0, lock: 0, per_raw:    0, per_avg:    0, stl: 0},
        '{gap: 1600, off: 0, lock: 1, per_raw: 1599, per_avg: 1599, stl: 0},
        '{gap: 1600, off: 5, lock: 1, per_raw: 1599, per_avg: 1599, stl: 0},
        '{gap: 2400, off: 5, lock: 1, per_raw: 2399, per_avg: 1699, stl: 0},
        '{gap: 1600, off: 5, lock: 1, per_raw: 1599, per_avg: 1686, stl: 1},
        '{gap: 4000, off: 0, lock: 0, per_raw: 1599, per_avg: 1686, stl: 0},
        '{gap: 1600, off: 0, lock: 1, per_raw: 1599, per_avg: 1599, stl: 0}
    };

    theta_tracker #(
        .COUNT_WIDTH    (CW),
        .ROTATIONAL_RES (RES),
        .DEBOUNCE_CYCLES(DEB),
        .STALL_CYCLES   (STALL),
        .AVG_LOG2       (AVG)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ir_tripped  (ir_tripped),
        .theta_offset(theta_offset),
        .dtheta      (dtheta),
        .dtheta_valid(dtheta_valid),
        .theta_step  (theta_step),
        .index_pulse (index_pulse),
        .period      (period),
        .stalled     (stalled)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    function automatic ev_t mk(input int c, input bit i, input bit s,
                               input bit st, input bit v, input int p,
                               input bit cn, input int dn,
                               input bit cx, input int dx);
        ev_t e;
        e.cyc = c;
        e.idx = i;
        e.stp = s;
        e.stl = st;
        e.vld = v;
        e.per = p;
        e.chk_now = cn;
        e.dt_now = dn;
        e.chk_nxt = cx;
        e.dt_nxt = dx;
        return e;
    endfunction

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk_in);
            if (pend) begin
                chk("dtheta_after_step", int'(dtheta), pend_dt);
                pend = 1'b0;
            end
            if (!rst_in &&
                (index_pulse || theta_step || (stalled != stl_prev))) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", cyc, -1);
                end else begin
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("index_pulse", int'(index_pulse), int'(e.idx));
                    chk("theta_step", int'(theta_step), int'(e.stp));
                    chk("stalled", int'(stalled), int'(e.stl));
                    chk("dtheta_valid", int'(dtheta_valid), int'(e.vld));
                    chk("period", int'(period), e.per);
                    if (e.chk_now) begin
                        chk("dtheta_now", int'(dtheta), e.dt_now);
                    end
                    if (e.chk_nxt) begin
                        pend = 1'b1;
                        pend_dt = e.dt_nxt;
                    end
                end
            end
            stl_prev = stalled;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int ang;
        int per_m;
        int off;
        int cp;
        int lim;
        int gap_next;
        int p;
        bit vld_m;
        bit stl_m;
        n = 40;
        ang = 0;
        per_m = 0;
        vld_m = 1'b0;
        stl_m = 1'b0;

        @(posedge clk_in);
        #1;
        goto(3);
        chk("rst_dtheta", int'(dtheta), 0);
        chk("rst_valid", int'(dtheta_valid), 0);
        chk("rst_step", int'(theta_step), 0);
        chk("rst_index", int'(index_pulse), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_stalled", int'(stalled), 0);
        goto(5);
        rst_in = 1'b0;

        // 3-cycle glitch must be rejected by the debounce
        goto(10);
        ir_tripped = 1'b1;
        goto(13);
        ir_tripped = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (i > 0) n = n + rows[i].gap;
            goto(n - 7);
            off = rows[i].off;
            theta_offset = 4'(off);
            q.push_back(mk(n, 1, 0, stl_m, vld_m, per_m,
                           1, (ang + off) % RES, 0, 0));
`ifdef THETA_PERIOD_AVG_EN
            per_m = rows[i].per_avg;
`else
            per_m = rows[i].per_raw;
`endif
            vld_m = rows[i].lock;
            stl_m = 1'b0;
            ang = 0;
            q.push_back(mk(n + 1, 0, 1, 0, vld_m, per_m, 0, 0, 1, off));
            gap_next = (i < 6) ? rows[i + 1].gap : 1600;
            lim = rows[i].stl ? STALL + 1 : gap_next;
            if (vld_m) begin
                cp = per_m / RES;
                if (cp < 1) cp = 1;
                for (int k = 1; k < RES; k++) begin
                    if (1 + k * cp < lim) begin
                        q.push_back(mk(n + 1 + k * cp, 0, 1, 0, 1, per_m,
                                       0, 0, 1, (k + off) % RES));
                        ang = k;
                    end
                end
            end
            if (rows[i].stl) begin
                q.push_back(mk(n + STALL + 1, 0, 0, 1, 0, per_m,
                               1, (ang + off) % RES, 1, off));
                vld_m = 1'b0;
                stl_m = 1'b1;
                ang = 0;
            end
            ir_tripped = 1'b1;
            goto(n - 3);
            ir_tripped = 1'b0;
        end

        goto(n + 1600);
        chk("queue_drained", q.size(), 0);

        // reset mid-debounce with ir held high: restart from scratch
        p = cyc;
        theta_offset = 4'd3;
        ir_tripped = 1'b1;
        q.push_back(mk(p + 12, 1, 0, 0, 0, 0, 1, 3, 0, 0));
        q.push_back(mk(p + 13, 0, 1, 0, 0, 0, 0, 0, 1, 3));
        goto(p + 4);
        rst_in = 1'b1;
        goto(p + 5);
        rst_in = 1'b0;
        chk("mid_rst_dtheta", int'(dtheta), 0);
        chk("mid_rst_valid", int'(dtheta_valid), 0);
        chk("mid_rst_period", int'(period), 0);
        chk("mid_rst_step", int'(theta_step), 0);
        chk("mid_rst_index", int'(index_pulse), 0);
        chk("mid_rst_stalled", int'(stalled), 0);
        goto(p + 40);
        ir_tripped = 1'b0;
        chk("final_queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
